// File: rtl/sr_writeback_pkg.sv
// Shared constants and the registered execute-bundle type for the sr_cpu writeback stage.
package sr_writeback_pkg;

   localparam logic [0:0] WB_ST_RUN   = 1'b0;
   localparam logic [0:0] WB_ST_FLUSH = 1'b1;
   localparam int         SR_WB_FLUSH_DEPTH = 2;

   typedef struct packed {
      logic        valid;
      logic        wdSrc;
      logic        regWrite;
      logic        branch;
      logic        condZero;
      logic        aluZero;
      logic [31:0] aluResult;
      logic [4:0]  rd;
      logic [31:0] immU;
      logic [31:0] pcBranch;
      logic [31:0] pcPlus4;
   } wbBundle_t;

endpackage

// File: rtl/sr_wb_flush_ctrl.sv
// Squash sequencer: after a taken branch, holds the pipe in FLUSH for FLUSH_DEPTH cycles.
module sr_wb_flush_ctrl
   import sr_writeback_pkg::*;
#(
   parameter int FLUSH_DEPTH = SR_WB_FLUSH_DEPTH
) (
   input  logic clk,
   input  logic rst,
   input  logic taken,
   output logic squash,
   output logic flush
);

   logic [0:0] state;
   logic [2:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= WB_ST_RUN;
         cnt   <= '0;
      end else if (state == WB_ST_RUN) begin
         // A depth of one squashes nothing beyond the branch cycle itself.
         if (taken && FLUSH_DEPTH > 1) begin
            state <= WB_ST_FLUSH;
            cnt   <= 3'(FLUSH_DEPTH - 1);
         end
      end else if (cnt == 3'd0) begin
         state <= WB_ST_RUN;
      end else begin
         cnt <= cnt - 3'd1;
      end
   end

   assign squash = (state == WB_ST_FLUSH);
   assign flush  = taken | squash;

endmodule

// File: rtl/sr_writeback.sv
// sr_cpu writeback stage: registers the execute bundle, drives the regfile write port, resolves branches.
// Define SR_WB_RETIRE_CNT_EN to build the retired-instruction counter on retired_o.
module sr_writeback
   import sr_writeback_pkg::*;
#(
   parameter int FLUSH_DEPTH = SR_WB_FLUSH_DEPTH,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_i,
   input  logic             wdSrc_i,
   input  logic             regWrite_i,
   input  logic             branch_i,
   input  logic             condZero_i,
   input  logic             aluZero_i,
   input  logic [31:0]      aluResult_i,
   input  logic [4:0]       rd_i,
   input  logic [31:0]      immU_i,
   input  logic [31:0]      pcBranch_i,
   input  logic [31:0]      pcPlus4_i,
   output logic             rfWe_o,
   output logic [4:0]       rfWa_o,
   output logic [31:0]      rfWd_o,
   output logic             pcSrc_o,
   output logic [31:0]      pcNext_o,
   output logic             flush_o,
   output logic [CNT_W-1:0] retired_o
);

   wbBundle_t bundleR;
   logic      squash;
   logic      live;
   logic      taken;
   logic      unusedPcPlus4;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bundleR <= '0;
      end else begin
         bundleR <= '{valid:     valid_i,
                      wdSrc:     wdSrc_i,
                      regWrite:  regWrite_i,
                      branch:    branch_i,
                      condZero:  condZero_i,
                      aluZero:   aluZero_i,
                      aluResult: aluResult_i,
                      rd:        rd_i,
                      immU:      immU_i,
                      pcBranch:  pcBranch_i,
                      pcPlus4:   pcPlus4_i};
      end
   end

   // Fall-through PC is kept only for debug visibility.
   assign unusedPcPlus4 = ^bundleR.pcPlus4;

   assign live  = bundleR.valid & ~squash;
   assign taken = live & bundleR.branch & (bundleR.aluZero == bundleR.condZero);

   assign rfWe_o   = live & bundleR.regWrite & (bundleR.rd != 5'd0);
   assign rfWa_o   = bundleR.rd;
   assign rfWd_o   = bundleR.wdSrc ? bundleR.immU : bundleR.aluResult;
   assign pcSrc_o  = taken;
   assign pcNext_o = taken ? bundleR.pcBranch : 32'd0;

   sr_wb_flush_ctrl #(.FLUSH_DEPTH(FLUSH_DEPTH)) uFlushCtrl (
      .clk    (clk),
      .rst    (rst),
      .taken  (taken),
      .squash (squash),
      .flush  (flush_o)
   );

`ifdef SR_WB_RETIRE_CNT_EN
   logic [CNT_W-1:0] retCnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       retCnt <= '0;
      else if (live) retCnt <= retCnt + CNT_W'(1);
   end

   assign retired_o = retCnt;
`else
   assign retired_o = '0;
`endif

endmodule

// File: tb/tb_sr_writeback.sv
// Directed plus random bench for sr_writeback against a squash-window reference model.
module tb_sr_writeback;
   import sr_writeback_pkg::*;

   localparam int FD = 2;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          valid_i, wdSrc_i, regWrite_i, branch_i, condZero_i, aluZero_i;
   logic [31:0]   aluResult_i, immU_i, pcBranch_i, pcPlus4_i;
   logic [4:0]    rd_i;
   logic          rfWe_o, pcSrc_o, flush_o;
   logic [4:0]    rfWa_o;
   logic [31:0]   rfWd_o, pcNext_o;
   logic [CW-1:0] retired_o;

   int nChk = 0;
   int nPass = 0;
   int squashLeft = 0;   // younger bundles still to be discarded
   int retCnt = 0;       // bundles retired so far (mod 2^CW)

   sr_writeback #(.FLUSH_DEPTH(FD), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .valid_i(valid_i), .wdSrc_i(wdSrc_i), .regWrite_i(regWrite_i),
      .branch_i(branch_i), .condZero_i(condZero_i), .aluZero_i(aluZero_i),
      .aluResult_i(aluResult_i), .rd_i(rd_i), .immU_i(immU_i),
      .pcBranch_i(pcBranch_i), .pcPlus4_i(pcPlus4_i),
      .rfWe_o(rfWe_o), .rfWa_o(rfWa_o), .rfWd_o(rfWd_o),
      .pcSrc_o(pcSrc_o), .pcNext_o(pcNext_o), .flush_o(flush_o),
      .retired_o(retired_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChk++;
      assert (obs === exp) nPass++;
      else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   function automatic wbBundle_t mk(input logic v, input logic ws, input logic rw,
                                    input logic br, input logic cz, input logic az,
                                    input logic [31:0] alu, input logic [4:0] rd,
                                    input logic [31:0] imm, input logic [31:0] pcb);
      wbBundle_t b;
      b = '{valid: v, wdSrc: ws, regWrite: rw, branch: br, condZero: cz, aluZero: az,
            aluResult: alu, rd: rd, immU: imm, pcBranch: pcb, pcPlus4: 32'hDEAD_0004};
      return b;
   endfunction

   task automatic drive(input wbBundle_t b);
      valid_i = b.valid;   wdSrc_i = b.wdSrc;       regWrite_i = b.regWrite;
      branch_i = b.branch; condZero_i = b.condZero; aluZero_i = b.aluZero;
      aluResult_i = b.aluResult; rd_i = b.rd; immU_i = b.immU;
      pcBranch_i = b.pcBranch;   pcPlus4_i = b.pcPlus4;
   endtask

   task automatic chkZero(input string tag);
      chk({tag, "_rfWe"}, 32'(rfWe_o), 32'd0);
      chk({tag, "_rfWa"}, 32'(rfWa_o), 32'd0);
      chk({tag, "_rfWd"}, rfWd_o, 32'd0);
      chk({tag, "_pcSrc"}, 32'(pcSrc_o), 32'd0);
      chk({tag, "_pcNext"}, pcNext_o, 32'd0);
      chk({tag, "_flush"}, 32'(flush_o), 32'd0);
      chk({tag, "_retired"}, 32'(retired_o), 32'd0);
   endtask

   // Present one bundle, clock it in, and check the stage outputs it produces.
   task automatic step(input string tag, input wbBundle_t b);
      logic live, taken;
      logic [31:0] expRet;
      drive(b);
      @(posedge clk);
      #1;
      live  = b.valid && (squashLeft == 0);
      taken = live && b.branch && (b.aluZero == b.condZero);
`ifdef SR_WB_RETIRE_CNT_EN
      expRet = 32'(retCnt);
`else
      expRet = 32'd0;
`endif
      chk({tag, "_rfWe"}, 32'(rfWe_o), 32'(live && b.regWrite && (b.rd != 5'd0)));
      chk({tag, "_rfWa"}, 32'(rfWa_o), 32'(b.rd));
      chk({tag, "_rfWd"}, rfWd_o, b.wdSrc ? b.immU : b.aluResult);
      chk({tag, "_pcSrc"}, 32'(pcSrc_o), 32'(taken));
      chk({tag, "_pcNext"}, pcNext_o, taken ? b.pcBranch : 32'd0);
      chk({tag, "_flush"}, 32'(flush_o), 32'(taken || (squashLeft > 0)));
      chk({tag, "_retired"}, 32'(retired_o), expRet);
      if (taken)               squashLeft = (FD > 1) ? FD : 0;
      else if (squashLeft > 0) squashLeft--;
      if (live) retCnt = (retCnt + 1) % (1 << CW);
   endtask

   initial begin
      wbBundle_t bub;
      wbBundle_t r;
      bub = mk(0, 0, 0, 0, 0, 0, 32'h0, 5'd0, 32'h0, 32'h0);
      rst = 1'b1;
      drive(mk(1, 0, 1, 0, 0, 0, 32'h55, 5'd9, 32'h0, 32'h0));
      #12;
      chkZero("reset");
      drive(bub);
      rst = 1'b0;

      step("bubble0", bub);
      step("aluWr",   mk(1, 0, 1, 0, 0, 0, 32'h0000_1234, 5'd5, 32'h0, 32'h0));
      step("x0Wr",    mk(1, 0, 1, 0, 0, 0, 32'h0000_1234, 5'd0, 32'h0, 32'h0));
      step("lui",     mk(1, 1, 1, 0, 0, 0, 32'hFFFF_FFFF, 5'd3, 32'hABCD_E000, 32'h0));

      step("brTaken", mk(1, 0, 0, 1, 1, 1, 32'h0, 5'd0, 32'h0, 32'h100));
      step("shadow1", mk(1, 0, 1, 0, 0, 0, 32'h77, 5'd7, 32'h0, 32'h0));
      step("shadow2", mk(1, 0, 1, 0, 0, 0, 32'h78, 5'd7, 32'h0, 32'h0));
      step("postWr",  mk(1, 0, 1, 0, 0, 0, 32'h79, 5'd7, 32'h0, 32'h0));
      step("brNot",   mk(1, 0, 0, 1, 1, 0, 32'h0, 5'd0, 32'h0, 32'h100));

      step("br200",   mk(1, 0, 0, 1, 0, 0, 32'h0, 5'd0, 32'h0, 32'h200));
      step("br300",   mk(1, 0, 0, 1, 0, 0, 32'h0, 5'd0, 32'h0, 32'h300));
      step("tail1",   bub);
      step("tail2",   bub);

      // Reset in the middle of a cycle with a live bundle and an active flush window.
      step("preRst",  mk(1, 0, 0, 1, 1, 1, 32'h0, 5'd4, 32'h0, 32'h400));
      #2 rst = 1'b1;
      #1;
      chkZero("midRst");
      squashLeft = 0;
      retCnt = 0;
      drive(bub);
      #3 rst = 1'b0;
      step("postRst", bub);

      for (int i = 0; i < 300; i++) begin
         r = mk($urandom_range(0, 9) < 8, 1'($urandom), $urandom_range(0, 3) != 0,
                $urandom_range(0, 9) < 2, 1'($urandom), 1'($urandom),
                $urandom, 5'($urandom), $urandom, $urandom);
         step("rand", r);
      end

      $display("%0d/%0d checks passed", nPass, nChk);
      $finish;
   end

endmodule
